rr_select_arbiter: RTL and testbench

RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

---
 rtl/rr_select_arbiter_if.sv | 42 ++++
 rtl/rr_select_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_select_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rr_select_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_select_arbiter_if
//   Bundles the request/grant signals of the round-robin select arbiter.
//
//   Signals:
//     req         [15:0]  request vector, bit i = requester i wants the resource
//     done                granted requester has finished (looked at only in BUSY)
//     select      [3:0]   index of the current or most recent winner
//     grant       [15:0]  one-hot grant, 1 << select while grant_valid is high
//     grant_valid         a grant is active
//     timeout             one-cycle pulse after a hold-limit force-release
//
//   Modports:
//     master : requester side (drives req/done, observes the arbiter outputs)
//     slave  : arbiter side   (observes req/done, drives the outputs)
// ---------------------------------------------------------------------------
interface rr_select_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  select;
  logic [15:0] grant;
  logic        grant_valid;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  select,
    input  grant,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output select,
    output grant,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_select_arbiter.sv
// ---------------------------------------------------------------------------
// rr_select_arbiter
//   Round-robin arbiter for a 16-way shared resource that is addressed
//   through a 4-to-16 decoder. A winner is chosen by a circular search that
//   starts at a rotating pointer; the grant is held until the requester
//   signals done, withdraws its request, or the hold limit expires. Every
//   grant is followed by one GAP cycle and one IDLE cycle.
//
//   Parameters:
//     MAX_HOLD : maximum number of BUSY cycles per grant (2..255)
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : rr_select_arbiter_if.slave (req/done in; select/grant/
//            grant_valid/timeout out, all outputs registered)
// ---------------------------------------------------------------------------
module rr_select_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_select_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  select_q, select_d;
  logic [15:0] grant_q, grant_d;
  logic        grant_valid_q, grant_valid_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  hold_q, hold_d;

  // Request vector rotated so that bit 0 corresponds to requester ptr_q.
  // The lowest set bit of the rotated vector is then the circular winner.
  logic [15:0] req_rot;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    logic [3:0] src_idx;
    assign src_idx     = ptr_q + 4'(gi);
    assign req_rot[gi] = bus.req[src_idx];
  end

  logic [3:0] win_offset;
  logic [3:0] winner;

  always_comb begin
    win_offset = 4'd0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_offset = 4'(i);
      end
    end
  end

  assign winner = ptr_q + win_offset;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    select_d      = select_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    hold_d        = hold_q;

    case (state_q)
      ST_IDLE: begin
        grant_d       = 16'h0000;
        grant_valid_d = 1'b0;
        if (|bus.req) begin
          state_d       = ST_BUSY;
          select_d      = winner;
          grant_d       = 16'h0001 << winner;
          grant_valid_d = 1'b1;
          ptr_d         = winner + 4'd1;
          hold_d        = 8'd0;
        end
      end

      ST_BUSY: begin
        // Priority: done, then withdrawal, then hold limit. Done and the
        // limit together is a normal completion, so no timeout pulse.
        if (bus.done) begin
          state_d       = ST_GAP;
          grant_d       = 16'h0000;
          grant_valid_d = 1'b0;
        end else if (!bus.req[select_q]) begin
          state_d       = ST_GAP;
          grant_d       = 16'h0000;
          grant_valid_d = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          state_d       = ST_GAP;
          grant_d       = 16'h0000;
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      ST_GAP: begin
        // Requests are deliberately ignored here; select keeps the last
        // winner so the decoder input does not glitch.
        state_d       = ST_IDLE;
        grant_d       = 16'h0000;
        grant_valid_d = 1'b0;
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = 16'h0000;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 4'd0;
      select_q      <= 4'd0;
      grant_q       <= 16'h0000;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      select_q      <= select_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      hold_q        <= hold_d;
    end
  end

  assign bus.select      = select_q;
  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_select_arbiter
//   Cycle-accurate vector bench for rr_select_arbiter (MAX_HOLD = 8).
//   Each record holds the inputs applied before a rising edge and the
//   outputs expected just after it. Expected records are queued when the
//   inputs are driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_rr_select_arbiter;

  typedef struct {
    string       tag;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        gv;
    logic        to;
  } vec_t;

  logic clk;
  logic rst;

  rr_select_arbiter_if bus ();

  rr_select_arbiter #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string t, logic r, logic [15:0] q, logic d,
                              logic [3:0] s, logic [15:0] g, logic v, logic o);
    vec_t x;
    x.tag = t; x.rst = r; x.req = q; x.done = d;
    x.sel = s; x.grant = g; x.gv = v; x.to = o;
    vecs.push_back(x);
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic [15:0] onehot;
    @(negedge clk);
    rst      = v.rst;
    bus.req  = v.req;
    bus.done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("%s: rst=%b req=%h done=%b -> select=%0d grant=%h gv=%b timeout=%b",
             e.tag, e.rst, e.req, e.done, bus.select, bus.grant, bus.grant_valid, bus.timeout);
    checks++;
    if (bus.select !== e.sel || bus.grant !== e.grant ||
        bus.grant_valid !== e.gv || bus.timeout !== e.to) begin
      errors++;
      $display("FAIL %s: got select=%0d grant=%h gv=%b timeout=%b, want select=%0d grant=%h gv=%b timeout=%b",
               e.tag, bus.select, bus.grant, bus.grant_valid, bus.timeout,
               e.sel, e.grant, e.gv, e.to);
    end
    // Structural invariant: grant is one-hot at select, or zero when invalid.
    onehot = bus.grant_valid ? (16'h0001 << bus.select) : 16'h0000;
    checks++;
    if (bus.grant !== onehot || bus.grant_valid !== (|bus.grant)) begin
      errors++;
      $display("FAIL %s_onehot: got grant=%h gv=%b, want grant=%h gv=%b",
               e.tag, bus.grant, bus.grant_valid, onehot, |bus.grant);
    end
  endtask

  task automatic rr_step(input string t, input logic [15:0] q, input logic d,
                         input logic [3:0] s, input logic [15:0] g, input logic v);
    vec_t x;
    x.tag = t; x.rst = 1'b0; x.req = q; x.done = d;
    x.sel = s; x.grant = g; x.gv = v; x.to = 1'b0;
    apply(x);
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = 16'h0000;
    bus.done = 1'b0;

    // ---- reset and single requester, done on 3rd BUSY cycle ----
    add("reset",        1, 16'h0000, 0, 4'd0, 16'h0000, 0, 0);
    add("single_grant", 0, 16'h0001, 0, 4'd0, 16'h0001, 1, 0);
    add("single_busy2", 0, 16'h0001, 0, 4'd0, 16'h0001, 1, 0);
    add("single_busy3", 0, 16'h0001, 0, 4'd0, 16'h0001, 1, 0);
    add("single_done",  0, 16'h0001, 1, 4'd0, 16'h0000, 0, 0);
    add("single_idle",  0, 16'h0001, 0, 4'd0, 16'h0000, 0, 0);
    // ptr is now 1: only bit 0 requesting wraps back to 0
    add("wrap_grant0",  0, 16'h0001, 0, 4'd0, 16'h0001, 1, 0);
    add("wrap_done",    0, 16'h0003, 1, 4'd0, 16'h0000, 0, 0);
    add("wrap_idle",    0, 16'h0003, 0, 4'd0, 16'h0000, 0, 0);
    // ptr = 1 with req 0x3 picks 1, ptr -> 2
    add("ptr1_grant1",  0, 16'h0003, 0, 4'd1, 16'h0002, 1, 0);
    add("ptr1_done",    0, 16'h0003, 1, 4'd1, 16'h0000, 0, 0);
    add("ptr1_idle",    0, 16'h0000, 0, 4'd1, 16'h0000, 0, 0);
    add("idle_hold",    0, 16'h0000, 0, 4'd1, 16'h0000, 0, 0);
    // ptr = 2, req 0x11: 4 wins, ptr -> 5, then 0 wins by wrap
    add("skip0_win4",   0, 16'h0011, 0, 4'd4, 16'h0010, 1, 0);
    add("win4_done",    0, 16'h0011, 1, 4'd4, 16'h0000, 0, 0);
    add("win4_idle",    0, 16'h0011, 0, 4'd4, 16'h0000, 0, 0);
    add("ptr5_win0",    0, 16'h0011, 0, 4'd0, 16'h0001, 1, 0);
    add("win0_done",    0, 16'h0011, 1, 4'd0, 16'h0000, 0, 0);
    add("win0_idle",    0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0);
    // ptr = 1: 8 wins; other req bits during BUSY have no effect
    add("win8",         0, 16'h0100, 0, 4'd8, 16'h0100, 1, 0);
    add("busy_noise1",  0, 16'h0101, 0, 4'd8, 16'h0100, 1, 0);
    add("busy_noise2",  0, 16'hFFFF, 0, 4'd8, 16'h0100, 1, 0);
    add("withdraw",     0, 16'hFEFF, 0, 4'd8, 16'h0000, 0, 0);
    add("withdraw_gap", 0, 16'h0000, 0, 4'd8, 16'h0000, 0, 0);
    add("withdraw_idl", 0, 16'h0000, 0, 4'd8, 16'h0000, 0, 0);
    // ptr = 9: hold limit, 8 BUSY cycles then timeout pulse
    add("to_grant9",    0, 16'h0200, 0, 4'd9, 16'h0200, 1, 0);
    for (int k = 0; k < 7; k++)
      add("to_busy",    0, 16'h0200, 0, 4'd9, 16'h0200, 1, 0);
    add("to_pulse",     0, 16'h0200, 0, 4'd9, 16'h0000, 0, 1);
    add("to_pulse_end", 0, 16'h0200, 0, 4'd9, 16'h0000, 0, 0);
    // ptr = 10, only 9 requesting: wrap to 9; done on the limit cycle
    add("lim_grant9",   0, 16'h0200, 0, 4'd9, 16'h0200, 1, 0);
    for (int k = 0; k < 7; k++)
      add("lim_busy",   0, 16'h0200, 0, 4'd9, 16'h0200, 1, 0);
    add("lim_done",     0, 16'h0200, 1, 4'd9, 16'h0000, 0, 0);
    add("lim_gap",      0, 16'h0000, 0, 4'd9, 16'h0000, 0, 0);
    // ptr = 10: grant 10, then reset mid-BUSY
    add("pre_rst_10",   0, 16'h0400, 0, 4'd10, 16'h0400, 1, 0);
    add("rst_busy",     1, 16'h0400, 0, 4'd0, 16'h0000, 0, 0);
    // ptr back at 0: 10 beats 12 (ptr 11 would have picked 12)
    add("post_rst_10",  0, 16'h1400, 0, 4'd10, 16'h0400, 1, 0);
    add("post_rst_dn",  0, 16'h1400, 1, 4'd10, 16'h0000, 0, 0);
    add("post_rst_gap", 0, 16'h0000, 0, 4'd10, 16'h0000, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // ---- full rotation with all requesters active ----
    begin
      vec_t r;
      r.tag = "rr_reset"; r.rst = 1'b1; r.req = 16'hFFFF; r.done = 1'b0;
      r.sel = 4'd0; r.grant = 16'h0000; r.gv = 1'b0; r.to = 1'b0;
      apply(r);
    end
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] w;
      w = 4'(k);
      rr_step("rr_grant", 16'hFFFF, 1'b0, w, 16'h0001 << w, 1'b1);
      rr_step("rr_done",  16'hFFFF, 1'b1, w, 16'h0000, 1'b0);
      rr_step("rr_idle",  16'hFFFF, 1'b0, w, 16'h0000, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
